// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the prefetching fetch unit.
// Widths here are the default parameter values of ifu_prefetch.
package ifu_prefetch_pkg;

  localparam int PC_SIZE    = 32;
  localparam int INSTR_SIZE = 32;
  localparam logic [INSTR_SIZE-1:0] INSTR_NOP = 32'h0000_0013;

  // Bits needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gnrl_dfflr.sv
// Generic load-enable flop bank, asynchronous active-low reset to zero.
module gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_lden,
  input  logic [DW-1:0] i_dnxt,
  output logic [DW-1:0] o_qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_qout <= '0;
    end else if (i_lden) begin
      o_qout <= i_dnxt;
    end
  end

endmodule

// File: rtl/ifu_pfq_fifo.sv
// Prefetch queue: circular buffer with one-bit-wider pointers so full and
// empty are distinguishable; flush drops every entry in one cycle.
module ifu_pfq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  r_wr_ptr;
  logic [AW:0]                  r_rd_ptr;
  logic [AW:0]                  w_wr_nxt;
  logic [AW:0]                  w_rd_nxt;
  logic                         w_wr_en;
  logic                         w_rd_en;
  logic [DEPTH-1:0][WIDTH-1:0]  w_mem;

  assign w_wr_en  = i_flush | i_push;
  assign w_rd_en  = i_flush | i_pop;
  assign w_wr_nxt = i_flush ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = i_flush ? '0 : r_rd_ptr + 1'b1;

  gnrl_dfflr #(.DW(AW+1)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .i_lden(w_wr_en), .i_dnxt(w_wr_nxt), .o_qout(r_wr_ptr)
  );

  gnrl_dfflr #(.DW(AW+1)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .i_lden(w_rd_en), .i_dnxt(w_rd_nxt), .o_qout(r_rd_ptr)
  );

  // Payload storage is not reset; the head is only looked at when cnt != 0.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] r_entry;
      always_ff @(posedge clk) begin
        if (i_push && !i_flush && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
          r_entry <= i_data;
        end
      end
      assign w_mem[gi] = r_entry;
    end
  endgenerate

  assign o_data = w_mem[r_rd_ptr[AW-1:0]];
  assign o_cnt  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: up to MAX_OUTSTD bus requests in flight,
// in-order responses buffered with their PC in a DEPTH-entry queue.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int PC_W       = PC_SIZE,
  parameter int INSTR_W    = INSTR_SIZE,
  parameter int DEPTH      = 4,
  parameter int MAX_OUTSTD = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PC_W-1:0]                   pc_rtvec,
  output logic                              ifu_req_valid,
  input  logic                              ifu_req_ready,
  output logic [PC_W-1:0]                   ifu_req_pc,
  input  logic                              ifu_rsp_valid,
  output logic                              ifu_rsp_ready,
  input  logic [INSTR_W-1:0]                ifu_rsp_instr,
  output logic                              ifu_o_valid,
  input  logic                              ifu_o_ready,
  output logic [INSTR_W-1:0]                ifu_o_ir,
  output logic [PC_W-1:0]                   ifu_o_pc,
  input  logic                              pipe_flush_req,
  input  logic [PC_W-1:0]                   pipe_flush_pc,
  output logic                              pipe_flush_ack,
  output logic [$clog2(MAX_OUTSTD+1)-1:0]   ifu_outstd
);

  localparam int OW = cnt_w(MAX_OUTSTD);
  localparam int CW = cnt_w(DEPTH);
  localparam int SW = cnt_w(DEPTH + MAX_OUTSTD);
  localparam int QW = PC_W + INSTR_W;

  logic              r_run;
  logic [PC_W-1:0]   r_fetch_pc;
  logic [PC_W-1:0]   r_rsp_pc;
  logic [OW-1:0]     r_outstd;
  logic [OW-1:0]     r_drop_cnt;

  logic [CW-1:0]     w_cnt;
  logic [QW-1:0]     w_head;
  logic [SW-1:0]     w_credit_used;
  logic [PC_W-1:0]   w_flush_pc;
  logic [PC_W-1:0]   w_rtvec;
  logic              w_req_hsk;
  logic              w_rsp_hsk;
  logic              w_o_hsk;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;

  logic              w_fetch_en;
  logic [PC_W-1:0]   w_fetch_nxt;
  logic              w_rsp_pc_en;
  logic [PC_W-1:0]   w_rsp_pc_nxt;
  logic              w_outstd_en;
  logic [OW-1:0]     w_outstd_nxt;
  logic              w_drop_en;
  logic [OW-1:0]     w_drop_nxt;

  assign w_flush_pc = pipe_flush_pc & ~PC_W'(3);
  assign w_rtvec    = pc_rtvec & ~PC_W'(3);

  // Slots already spoken for: buffered entries plus responses that will be kept.
  assign w_credit_used = SW'(w_cnt) + SW'(r_outstd) - SW'(r_drop_cnt);

  assign ifu_req_valid = r_run & ~pipe_flush_req
                       & (r_outstd < OW'(MAX_OUTSTD))
                       & (w_credit_used < SW'(DEPTH));
  assign ifu_req_pc    = r_fetch_pc;
  assign ifu_rsp_ready = 1'b1;
  assign pipe_flush_ack = 1'b1;
  assign ifu_outstd    = r_outstd;

  assign w_req_hsk = ifu_req_valid & ifu_req_ready;
  assign w_rsp_hsk = ifu_rsp_valid;
  assign w_o_hsk   = ifu_o_valid & ifu_o_ready;
  assign w_drop    = w_rsp_hsk & (r_drop_cnt != '0);
  assign w_push    = w_rsp_hsk & ~w_drop & ~pipe_flush_req;
  assign w_pop     = w_o_hsk & ~pipe_flush_req;

  // The reset vector is captured on the first clock after reset release,
  // which is also the edge that sets run.
  assign w_fetch_en  = pipe_flush_req | ~r_run | w_req_hsk;
  assign w_fetch_nxt = pipe_flush_req ? w_flush_pc :
                       (~r_run ? w_rtvec : r_fetch_pc + PC_W'(4));

  assign w_rsp_pc_en  = pipe_flush_req | ~r_run | w_push;
  assign w_rsp_pc_nxt = pipe_flush_req ? w_flush_pc :
                        (~r_run ? w_rtvec : r_rsp_pc + PC_W'(4));

  assign w_outstd_en  = w_req_hsk | w_rsp_hsk;
  assign w_outstd_nxt = r_outstd + OW'(w_req_hsk) - OW'(w_rsp_hsk);

  assign w_drop_en  = pipe_flush_req | w_drop;
  assign w_drop_nxt = pipe_flush_req ? (r_outstd - OW'(w_rsp_hsk)) : (r_drop_cnt - 1'b1);

  gnrl_dfflr #(.DW(1)) u_run (
    .clk(clk), .rst_n(rst_n), .i_lden(~r_run), .i_dnxt(1'b1), .o_qout(r_run)
  );

  gnrl_dfflr #(.DW(PC_W)) u_fetch_pc (
    .clk(clk), .rst_n(rst_n), .i_lden(w_fetch_en), .i_dnxt(w_fetch_nxt), .o_qout(r_fetch_pc)
  );

  gnrl_dfflr #(.DW(PC_W)) u_rsp_pc (
    .clk(clk), .rst_n(rst_n), .i_lden(w_rsp_pc_en), .i_dnxt(w_rsp_pc_nxt), .o_qout(r_rsp_pc)
  );

  gnrl_dfflr #(.DW(OW)) u_outstd (
    .clk(clk), .rst_n(rst_n), .i_lden(w_outstd_en), .i_dnxt(w_outstd_nxt), .o_qout(r_outstd)
  );

  gnrl_dfflr #(.DW(OW)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .i_lden(w_drop_en), .i_dnxt(w_drop_nxt), .o_qout(r_drop_cnt)
  );

  ifu_pfq_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_pfq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (pipe_flush_req),
    .i_data  ({r_rsp_pc, ifu_rsp_instr}),
    .o_data  (w_head),
    .o_cnt   (w_cnt)
  );

  // Head fields are forced to zero while empty so idle outputs read as 0.
  assign ifu_o_valid = (w_cnt != '0);
  assign ifu_o_pc    = ifu_o_valid ? w_head[QW-1:INSTR_W] : '0;
  assign ifu_o_ir    = ifu_o_valid ? w_head[INSTR_W-1:0] : '0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: bus memory model with configurable
// latency, scoreboard of expected {pc, instr} in delivery order.
module tb_ifu_prefetch;

  localparam int PC_W       = 32;
  localparam int INSTR_W    = 32;
  localparam int DEPTH      = 4;
  localparam int MAX_OUTSTD = 2;
  localparam int OW         = $clog2(MAX_OUTSTD+1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PC_W-1:0]    pc_rtvec = '0;
  logic               ifu_req_valid;
  logic               ifu_req_ready = 1'b0;
  logic [PC_W-1:0]    ifu_req_pc;
  logic               ifu_rsp_valid = 1'b0;
  logic               ifu_rsp_ready;
  logic [INSTR_W-1:0] ifu_rsp_instr = '0;
  logic               ifu_o_valid;
  logic               ifu_o_ready = 1'b0;
  logic [INSTR_W-1:0] ifu_o_ir;
  logic [PC_W-1:0]    ifu_o_pc;
  logic               pipe_flush_req = 1'b0;
  logic [PC_W-1:0]    pipe_flush_pc = '0;
  logic               pipe_flush_ack;
  logic [OW-1:0]      ifu_outstd;

  always #5 clk = ~clk;

  ifu_prefetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .MAX_OUTSTD(MAX_OUTSTD)) dut (
    .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir), .ifu_o_pc(ifu_o_pc),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack),
    .ifu_outstd(ifu_outstd)
  );

  typedef struct { logic [31:0] pc; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  logic [31:0] pop_log[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int epoch = 0;
  int last_due = 0;
  int lat = 1;
  int pops = 0;
  int peak_outstd = 0;
  int first_req_cyc = -1;
  int first_oval_cyc = -1;
  bit rand_req_ready = 0;
  bit rand_o_ready = 0;
  bit rand_lat = 0;
  bit o_ready_knob = 1;
  bit pend_flush = 0;
  bit coinc_arm = 0;
  bit second_arm = 0;
  bit coinc_fired = 0;
  bit prev_req_stall = 0;
  logic [31:0] prev_req_pc = '0;
  logic [31:0] flush_tgt = '0;
  logic [31:0] model_pc = '0;

  mreq_t h;
  exp_t  e;
  bit    rsp_now;
  bit    fl;
  int    due;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h5A5A, pc[31:16]};
  endfunction

  // One bus cycle: drive inputs on the falling edge, sample 1ns later,
  // and advance the memory model and scoreboard with what commits next edge.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      ifu_req_ready = rand_req_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      ifu_o_ready   = rand_o_ready ? ($urandom_range(0, 1) == 1) : o_ready_knob;
      rsp_now       = (memq.size() != 0) && (memq[0].due <= cyc);
      ifu_rsp_valid = rsp_now;
      ifu_rsp_instr = rsp_now ? instr_of(memq[0].pc) : 32'h0;
      fl = pend_flush;
      pend_flush = 0;
      if (second_arm) begin
        fl = 1; flush_tgt = 32'h200; second_arm = 0;
      end else if (coinc_arm && rsp_now && ifu_o_valid && ifu_o_ready) begin
        fl = 1; flush_tgt = 32'h180; coinc_arm = 0; second_arm = 1; coinc_fired = 1;
      end
      pipe_flush_req = fl;
      pipe_flush_pc  = flush_tgt;
      #1;
      n_cmp++;
      if (ifu_outstd !== OW'(memq.size())) begin
        n_err++; $display("FAIL outstd cyc=%0d: got %0d want %0d", cyc, ifu_outstd, memq.size());
      end
      if (int'(ifu_outstd) > peak_outstd) peak_outstd = int'(ifu_outstd);
      n_cmp++;
      if (ifu_o_valid !== (expq.size() != 0)) begin
        n_err++; $display("FAIL o_valid cyc=%0d: got %b want %b", cyc, ifu_o_valid, expq.size() != 0);
      end
      n_cmp++;
      if (ifu_req_valid === 1'b1 && memq.size() >= MAX_OUTSTD) begin
        n_err++; $display("FAIL credit cyc=%0d: got req_valid=1 want 0 with %0d in flight", cyc, memq.size());
      end
      if (prev_req_stall && !fl) begin
        n_cmp++;
        if (ifu_req_valid !== 1'b1 || ifu_req_pc !== prev_req_pc) begin
          n_err++; $display("FAIL req_hold cyc=%0d: got v=%b pc=%h want v=1 pc=%h", cyc, ifu_req_valid, ifu_req_pc, prev_req_pc);
        end
      end
      prev_req_stall = ifu_req_valid && !ifu_req_ready;
      prev_req_pc    = ifu_req_pc;
      if (ifu_o_valid === 1'b1 && first_oval_cyc < 0) first_oval_cyc = cyc;
      if (rsp_now) h = memq.pop_front();
      if (fl) begin
        n_cmp++;
        if (ifu_req_valid !== 1'b0) begin
          n_err++; $display("FAIL req_in_flush cyc=%0d: got 1 want 0", cyc);
        end
        expq.delete();
        pop_log.delete();
        epoch++;
        model_pc = flush_tgt & ~32'h3;
        prev_req_stall = 0;
      end else begin
        if (ifu_o_valid === 1'b1 && ifu_o_ready && expq.size() != 0) begin
          e = expq.pop_front();
          n_cmp++;
          if (ifu_o_pc !== e.pc || ifu_o_ir !== e.ir) begin
            n_err++; $display("FAIL o_data cyc=%0d: got pc=%h ir=%h want pc=%h ir=%h", cyc, ifu_o_pc, ifu_o_ir, e.pc, e.ir);
          end
          pops++;
          pop_log.push_back(ifu_o_pc);
        end
        if (rsp_now && h.epoch == epoch) begin
          expq.push_back('{h.pc, instr_of(h.pc)});
          n_cmp++;
          if (expq.size() > DEPTH) begin
            n_err++; $display("FAIL overflow cyc=%0d: got %0d buffered want <=%0d", cyc, expq.size(), DEPTH);
          end
        end
        if (ifu_req_valid === 1'b1 && ifu_req_ready) begin
          n_cmp++;
          if (ifu_req_pc !== model_pc) begin
            n_err++; $display("FAIL req_pc cyc=%0d: got %h want %h", cyc, ifu_req_pc, model_pc);
          end
          if (first_req_cyc < 0) first_req_cyc = cyc;
          due = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
          if (due <= last_due) due = last_due + 1;
          memq.push_back('{model_pc, due, epoch});
          last_due = due;
          model_pc = model_pc + 32'd4;
        end
      end
      cyc++;
    end
  endtask

  task automatic hold_reset(input logic [31:0] vec);
    @(negedge clk);
    rst_n = 1'b0;
    pc_rtvec = vec;
    ifu_rsp_valid = 1'b0;
    pipe_flush_req = 1'b0;
    memq.delete(); expq.delete(); pop_log.delete();
    prev_req_stall = 0; pend_flush = 0; coinc_arm = 0; second_arm = 0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Release just after a rising edge so the next sampled cycle is cycle 0.
  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_pc = pc_rtvec & ~32'h3;
    cyc = 0; last_due = 0; first_req_cyc = -1; first_oval_cyc = -1;
  endtask

  task automatic test_reset();
    hold_reset(32'h8000_0002);
    n_cmp++;
    if ({ifu_req_valid, ifu_o_valid, ifu_outstd} !== '0 || ifu_req_pc !== '0 || ifu_o_pc !== '0 || ifu_o_ir !== '0) begin
      n_err++; $display("FAIL reset_outputs: got rv=%b pc=%h ov=%b opc=%h oir=%h os=%0d want all 0", ifu_req_valid, ifu_req_pc, ifu_o_valid, ifu_o_pc, ifu_o_ir, ifu_outstd);
    end
    n_cmp++;
    if (ifu_rsp_ready !== 1'b1 || pipe_flush_ack !== 1'b1) begin
      n_err++; $display("FAIL reset_readies: got rsp_ready=%b flush_ack=%b want 1 1", ifu_rsp_ready, pipe_flush_ack);
    end
    lat = 1; o_ready_knob = 1;
    release_reset();
    run_cycles(12);
    n_cmp++;
    if (first_req_cyc != 1) begin
      n_err++; $display("FAIL first_req: got cycle %0d want 1", first_req_cyc);
    end
    n_cmp++;
    if (first_oval_cyc != 3) begin
      n_err++; $display("FAIL first_o_valid: got cycle %0d want 3", first_oval_cyc);
    end
    n_cmp++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'h8000_0000 || pop_log[1] !== 32'h8000_0004) begin
      n_err++; $display("FAIL first_pcs: got %0d pops head=%h want 80000000,80000004", pop_log.size(), pop_log.size() ? pop_log[0] : 32'h0);
    end
  endtask

  task automatic test_backpressure();
    bit contiguous;
    o_ready_knob = 0;
    run_cycles(20);
    n_cmp++;
    if (ifu_o_valid !== 1'b1 || ifu_req_valid !== 1'b0 || ifu_outstd !== '0) begin
      n_err++; $display("FAIL stall_state: got ov=%b rv=%b os=%0d want 1 0 0", ifu_o_valid, ifu_req_valid, ifu_outstd);
    end
    pop_log.delete();
    o_ready_knob = 1;
    run_cycles(12);
    contiguous = (pop_log.size() >= 8);
    for (int i = 1; i < pop_log.size(); i++)
      if (pop_log[i] !== pop_log[i-1] + 32'd4) contiguous = 0;
    n_cmp++;
    if (!contiguous) begin
      n_err++; $display("FAIL stall_resume: got %0d pops non-contiguous=%b want >=8 contiguous", pop_log.size(), !contiguous);
    end
  endtask

  task automatic test_latency();
    lat = 5;
    run_cycles(10);
    peak_outstd = 0;
    pops = 0;
    run_cycles(60);
    n_cmp++;
    if (peak_outstd != MAX_OUTSTD) begin
      n_err++; $display("FAIL outstd_peak: got %0d want %0d", peak_outstd, MAX_OUTSTD);
    end
    n_cmp++;
    if (pops < 18 || pops > 24) begin
      n_err++; $display("FAIL latency_throughput: got %0d pops in 60 cycles want 18..24", pops);
    end
  endtask

  task automatic test_flush();
    int guard;
    lat = 3;
    guard = 0;
    while (memq.size() != 2 && guard < 50) begin run_cycles(1); guard++; end
    flush_tgt = 32'h0000_0102;
    pend_flush = 1;
    run_cycles(1);
    @(posedge clk); #1;
    n_cmp++;
    if (ifu_o_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_head: got o_valid=%b want 0", ifu_o_valid);
    end
    guard = 0;
    while (pop_log.size() < 2 && guard < 40) begin run_cycles(1); guard++; end
    n_cmp++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104) begin
      n_err++; $display("FAIL flush_target: got %0d pops head=%h want 00000100,00000104", pop_log.size(), pop_log.size() ? pop_log[0] : 32'h0);
    end
  endtask

  task automatic test_flush_coincident();
    int guard;
    lat = 2;
    run_cycles(6);
    coinc_fired = 0;
    coinc_arm = 1;
    guard = 0;
    while (!(coinc_fired && !second_arm && pop_log.size() >= 2) && guard < 60) begin run_cycles(1); guard++; end
    coinc_arm = 0;
    n_cmp++;
    if (!coinc_fired || pop_log.size() < 2 || pop_log[0] !== 32'h200 || pop_log[1] !== 32'h204) begin
      n_err++; $display("FAIL flush_back_to_back: got fired=%b pops=%0d head=%h want 00000200,00000204", coinc_fired, pop_log.size(), pop_log.size() ? pop_log[0] : 32'h0);
    end
  endtask

  task automatic test_wrap();
    int guard;
    lat = 1;
    flush_tgt = 32'hFFFF_FFF9;
    pend_flush = 1;
    guard = 0;
    run_cycles(1);
    while (pop_log.size() < 3 && guard < 40) begin run_cycles(1); guard++; end
    n_cmp++;
    if (pop_log.size() < 3 || pop_log[1] !== 32'hFFFF_FFFC || pop_log[2] !== 32'h0) begin
      n_err++; $display("FAIL pc_wrap: got %0d pops third=%h want fffffffc then 00000000", pop_log.size(), pop_log.size() > 2 ? pop_log[2] : 32'hX);
    end
  endtask

  task automatic test_random();
    rand_req_ready = 1; rand_o_ready = 1; rand_lat = 1;
    for (int k = 0; k < 6; k++) begin
      run_cycles(50);
      flush_tgt = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'h40;
      pend_flush = 1;
    end
    rand_req_ready = 0; rand_o_ready = 0; rand_lat = 0; o_ready_knob = 1;
    run_cycles(20);
  endtask

  task automatic test_reset_mid();
    hold_reset(32'h0000_1003);
    n_cmp++;
    if (ifu_req_valid !== 1'b0 || ifu_o_valid !== 1'b0 || ifu_outstd !== '0) begin
      n_err++; $display("FAIL reset_mid: got rv=%b ov=%b os=%0d want 0 0 0", ifu_req_valid, ifu_o_valid, ifu_outstd);
    end
    release_reset();
    run_cycles(10);
    n_cmp++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h0000_1000) begin
      n_err++; $display("FAIL reset_mid_vector: got %0d pops head=%h want 00001000", pop_log.size(), pop_log.size() ? pop_log[0] : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_latency();
    test_flush();
    test_flush_coincident();
    test_wrap();
    test_random();
    lat = 2;
    run_cycles(5);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
